// File: rtl/noc_switch_allocator.sv
// noc_switch_allocator: round-robin wormhole switch allocator for a 5-port (N,S,E,W,L) router crossbar
// Ports: in_req/in_dest/in_tail describe each input's head flit; out_ready is downstream space per output.
// in_grant pops input buffers, out_valid and *_port_select drive the crossbar (3'b111 = idle),
// alloc_err pulses while an unlocked input asks for itself or a nonexistent port.
module noc_switch_allocator #(
  parameter bit ENABLE_LOCK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  in_req,
  input  logic [14:0] in_dest,
  input  logic [4:0]  in_tail,
  input  logic [4:0]  out_ready,
  output logic [4:0]  in_grant,
  output logic [4:0]  out_valid,
  output logic [2:0]  N_port_select,
  output logic [2:0]  S_port_select,
  output logic [2:0]  E_port_select,
  output logic [2:0]  W_port_select,
  output logic [2:0]  L_port_select,
  output logic        alloc_err
);
  logic [4:0] lock_v, locked, cand_v, fire;
  logic [2:0] lock_src [5];
  logic [2:0] rr_ptr [5];
  logic [2:0] cand [5];
  logic [2:0] dest [5];
  logic [2:0] sel [5];
  logic [2:0] s;
  always_comb begin
    locked = '0;
    cand_v = '0;
    fire = '0;
    in_grant = '0;
    alloc_err = 1'b0;
    s = '0;
    for (int i = 0; i < 5; i++) dest[i] = in_dest[3*i +: 3];
    for (int o = 0; o < 5; o++) begin
      cand[o] = 3'd0;
      sel[o] = 3'b111;
      if (lock_v[o]) locked[lock_src[o]] = 1'b1;
    end
    // Locked outputs follow their owner (body flits carry no valid dest);
    // unlocked outputs scan inputs starting at rr_ptr.
    for (int o = 0; o < 5; o++) begin
      if (lock_v[o]) begin
        cand[o] = lock_src[o];
        cand_v[o] = in_req[lock_src[o]];
      end else begin
        for (int k = 0; k < 5; k++) begin
          s = 3'((int'(rr_ptr[o]) + k) % 5);
          if (!cand_v[o] && in_req[s] && !locked[s] && dest[s] == 3'(o) && s != 3'(o)) begin
            cand_v[o] = 1'b1;
            cand[o] = s;
          end
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      fire[o] = rst_n && cand_v[o] && out_ready[o];
      if (fire[o]) begin
        sel[o] = cand[o];
        in_grant[cand[o]] = 1'b1;
      end
    end
    for (int i = 0; i < 5; i++)
      if (rst_n && in_req[i] && !locked[i] && (dest[i] > 3'd4 || dest[i] == 3'(i))) alloc_err = 1'b1;
  end
  assign out_valid = fire;
  assign N_port_select = sel[0];
  assign S_port_select = sel[1];
  assign E_port_select = sel[2];
  assign W_port_select = sel[3];
  assign L_port_select = sel[4];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_v <= '0;
      for (int o = 0; o < 5; o++) begin
        lock_src[o] <= 3'd0;
        rr_ptr[o] <= 3'd0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (fire[o]) begin
          if (ENABLE_LOCK && !in_tail[cand[o]]) begin
            lock_v[o] <= 1'b1;
            lock_src[o] <= cand[o];
          end else begin
            lock_v[o] <= 1'b0;
            rr_ptr[o] <= cand[o] == 3'd4 ? 3'd0 : cand[o] + 3'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_switch_allocator.sv
// tb_noc_switch_allocator: directed vectors checked against literals and a per-cycle allocator model
module tb_noc_switch_allocator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  in_req = '0;
  logic [14:0] in_dest = '0;
  logic [4:0]  in_tail = '0;
  logic [4:0]  out_ready = '0;
  logic [4:0]  in_grant, out_valid;
  logic [2:0]  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select;
  logic        alloc_err;
  int passed = 0;
  int total = 0;

  noc_switch_allocator #(.ENABLE_LOCK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_dest(in_dest), .in_tail(in_tail),
    .out_ready(out_ready), .in_grant(in_grant), .out_valid(out_valid),
    .N_port_select(N_port_select), .S_port_select(S_port_select), .E_port_select(E_port_select),
    .W_port_select(W_port_select), .L_port_select(L_port_select), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [14:0] dst(input int n, input int s, input int e, input int w, input int l);
    return {3'(l), 3'(w), 3'(e), 3'(s), 3'(n)};
  endfunction

  function automatic logic [14:0] sels();
    return {L_port_select, W_port_select, E_port_select, S_port_select, N_port_select};
  endfunction

  task automatic drive(input logic r, input logic [4:0] req, input logic [14:0] d,
                       input logic [4:0] tail, input logic [4:0] rdy);
    @(posedge clk);
    #1;
    rst_n = r;
    in_req = req;
    in_dest = d;
    in_tail = tail;
    out_ready = rdy;
    #3;
  endtask

  // Model: owner per output (-1 = free) and round-robin start per output.
  int m_own [5];
  int m_ptr [5];
  int m_c [5];
  int m_bd, m_d;
  logic [4:0] m_lk, m_g, m_v;
  logic [14:0] m_s;
  logic m_e;
  initial for (int o = 0; o < 5; o++) begin m_own[o] = -1; m_ptr[o] = 0; end

  always @(negedge clk) begin
    m_g = '0; m_v = '0; m_s = '1; m_e = 1'b0; m_lk = '0;
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) begin m_own[o] = -1; m_ptr[o] = 0; end
    end else begin
      for (int o = 0; o < 5; o++) if (m_own[o] >= 0) m_lk[m_own[o]] = 1'b1;
      for (int o = 0; o < 5; o++) begin
        m_c[o] = -1;
        if (m_own[o] >= 0) begin
          if (in_req[m_own[o]]) m_c[o] = m_own[o];
        end else begin
          m_bd = 5;
          for (int i = 0; i < 5; i++)
            if (!m_lk[i] && in_req[i] && int'(in_dest[3*i +: 3]) == o && i != o) begin
              m_d = (i - m_ptr[o] + 5) % 5;
              if (m_d < m_bd) begin m_bd = m_d; m_c[o] = i; end
            end
        end
      end
      for (int i = 0; i < 5; i++)
        if (!m_lk[i] && in_req[i] && (int'(in_dest[3*i +: 3]) > 4 || int'(in_dest[3*i +: 3]) == i)) m_e = 1'b1;
      for (int o = 0; o < 5; o++)
        if (m_c[o] >= 0 && out_ready[o]) begin
          m_v[o] = 1'b1;
          m_g[m_c[o]] = 1'b1;
          m_s[3*o +: 3] = 3'(m_c[o]);
          if (!in_tail[m_c[o]]) m_own[o] = m_c[o];
          else begin m_own[o] = -1; m_ptr[o] = (m_c[o] + 1) % 5; end
        end
    end
    chk("model_grant", 32'(in_grant), 32'(m_g));
    chk("model_valid", 32'(out_valid), 32'(m_v));
    chk("model_sel", 32'(sels()), 32'(m_s));
    chk("model_err", 32'(alloc_err), 32'(m_e));
  end

  initial begin
    // Reset with every input requesting
    drive(0, 5'b11111, dst(1,0,0,0,0), 5'b11111, 5'b11111);
    drive(0, 5'b11111, dst(1,0,0,0,0), 5'b11111, 5'b11111);
    chk("rst_grant", 32'(in_grant), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(sels()), 32'h7fff);
    chk("rst_err", 32'(alloc_err), 0);
    drive(1, 5'b00000, 15'd0, 5'b11111, 5'b11111);
    chk("idle_valid", 32'(out_valid), 0);
    // Round robin on L: N, E, W
    drive(1, 5'b01101, dst(4,0,4,4,0), 5'b11111, 5'b11111);
    chk("rr1_grant", 32'(in_grant), 32'b00001);
    chk("rr1_lsel", 32'(L_port_select), 0);
    drive(1, 5'b01101, dst(4,0,4,4,0), 5'b11111, 5'b11111);
    chk("rr2_grant", 32'(in_grant), 32'b00100);
    chk("rr2_lsel", 32'(L_port_select), 2);
    drive(1, 5'b01101, dst(4,0,4,4,0), 5'b11111, 5'b11111);
    chk("rr3_grant", 32'(in_grant), 32'b01000);
    chk("rr3_lsel", 32'(L_port_select), 3);
    // Single flit S->L, then N vs E probes rr_ptr[L]=2
    drive(1, 5'b00010, dst(0,4,0,0,0), 5'b11111, 5'b11111);
    chk("sf_grant", 32'(in_grant), 32'b00010);
    chk("sf_lsel", 32'(L_port_select), 1);
    chk("sf_valid", 32'(out_valid), 32'b10000);
    drive(1, 5'b00101, dst(4,0,4,0,0), 5'b11111, 5'b11111);
    chk("ptr_grant", 32'(in_grant), 32'b00100);
    // Wormhole E->N with W contending
    drive(1, 5'b01100, dst(0,0,0,0,0), 5'b01000, 5'b11111);
    chk("wh1_grant", 32'(in_grant), 32'b00100);
    chk("wh1_nsel", 32'(N_port_select), 2);
    drive(1, 5'b01000, dst(0,0,0,0,0), 5'b01000, 5'b11111);
    chk("wh_bubble_grant", 32'(in_grant), 0);
    chk("wh_bubble_valid", 32'(out_valid), 0);
    drive(1, 5'b01100, dst(0,0,1,0,0), 5'b01000, 5'b11111);
    chk("wh2_grant", 32'(in_grant), 32'b00100);
    chk("wh2_nsel", 32'(N_port_select), 2);
    drive(1, 5'b01100, dst(0,0,1,0,0), 5'b01100, 5'b11111);
    chk("wh3_grant", 32'(in_grant), 32'b00100);
    drive(1, 5'b01000, dst(0,0,0,0,0), 5'b01000, 5'b11111);
    chk("wh_w_grant", 32'(in_grant), 32'b01000);
    chk("wh_w_nsel", 32'(N_port_select), 3);
    // Backpressure on locked N->S with L waiting
    drive(1, 5'b10001, dst(1,0,0,0,1), 5'b10000, 5'b11111);
    chk("bp1_grant", 32'(in_grant), 32'b00001);
    chk("bp1_ssel", 32'(S_port_select), 0);
    drive(1, 5'b10001, dst(1,0,0,0,1), 5'b10000, 5'b11101);
    chk("bp_hold_grant", 32'(in_grant), 0);
    drive(1, 5'b10001, dst(1,0,0,0,1), 5'b10000, 5'b11101);
    chk("bp_hold_valid", 32'(out_valid), 0);
    drive(1, 5'b10001, dst(1,0,0,0,1), 5'b10000, 5'b11111);
    chk("bp2_grant", 32'(in_grant), 32'b00001);
    drive(1, 5'b10001, dst(1,0,0,0,1), 5'b10001, 5'b11111);
    chk("bp3_grant", 32'(in_grant), 32'b00001);
    drive(1, 5'b10000, dst(1,0,0,0,1), 5'b10000, 5'b11111);
    chk("bp_l_grant", 32'(in_grant), 32'b10000);
    chk("bp_l_ssel", 32'(S_port_select), 4);
    // Illegal heads alongside a legal N->L flit
    for (int c = 0; c < 2; c++) begin
      drive(1, 5'b01011, dst(4,6,0,3,0), 5'b11111, 5'b11111);
      chk("ill_err", 32'(alloc_err), 1);
      chk("ill_grant", 32'(in_grant), 32'b00001);
      chk("ill_lsel", 32'(L_port_select), 0);
    end
    drive(1, 5'b00000, 15'd0, 5'b11111, 5'b11111);
    chk("ill_clear", 32'(alloc_err), 0);
    // Reset mid-packet drops the E->W lock
    drive(1, 5'b00100, dst(0,0,3,0,0), 5'b00000, 5'b11111);
    chk("mr_grant", 32'(in_grant), 32'b00100);
    chk("mr_wsel", 32'(W_port_select), 2);
    drive(0, 5'b00100, dst(0,0,3,0,0), 5'b00000, 5'b11111);
    chk("mr_rst_grant", 32'(in_grant), 0);
    drive(1, 5'b00100, dst(0,0,0,0,0), 5'b00000, 5'b11111);
    chk("mr_head_nsel", 32'(N_port_select), 2);
    chk("mr_head_wsel", 32'(W_port_select), 7);
    drive(1, 5'b00100, dst(0,0,0,0,0), 5'b00100, 5'b11111);
    chk("mr_tail_grant", 32'(in_grant), 32'b00100);
    drive(1, 5'b00000, 15'd0, 5'b11111, 5'b11111);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Wormhole switch allocator for the 5-port router.
- Sits directly upstream of the crossbar. It takes flit requests from the five input buffers (N, S, E, W, L) and arbitrates each output port round-robin.
- It drives the crossbar's five 3-bit port selects, returns per-input grants (buffer pop) and per-output valids.
- An output stays locked to one input from head flit to tail flit.

Parameters:
- ENABLE_LOCK, 1: 1 = wormhole locking (packet held until tail); 0 = every flit arbitrated independently, as if every flit were a tail.

Ports:
- clk  in  1  router clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_req  in  5  per-input flit valid; bit index = port: N=0, S=1, E=2, W=3, L=4.
- in_dest  in  15  per-input requested output, 3 bits per input: [3i+2:3i]. Same port encoding as in_req.
- in_tail  in  5  per-input: current flit is the last flit of its packet.
- out_ready  in  5  per-output: downstream can accept a flit this cycle.
- in_grant  out  5  per-input: flit transferred this cycle, buffer pops.
- out_valid  out  5  per-output: crossbar output carries a valid flit this cycle.
- N_port_select, S_port_select, E_port_select, W_port_select, L_port_select  out  3 each  crossbar select = source input index (0-4); 3'b111 when idle.
- alloc_err  out  1  one-cycle pulse: an illegal head request is present.

Behaviour:
- Ports are numbered N=0, S=1, E=2, W=3, L=4 for inputs, outputs and select values.
- State per output o:
  - lock_v[o] and lock_src[o][2:0]: owner of the output.
  - rr_ptr[o][2:0]: highest-priority candidate, range 0-4.
- Reset (rst_n=0 at posedge):
  - lock_v=0, lock_src=0, rr_ptr=0 for all outputs.
  - While rst_n=0, outputs are forced: in_grant=0, out_valid=0, all selects=3'b111, alloc_err=0.
- Input i is locked if some output has lock_v=1 and lock_src=i.
- A locked input is routed to its owner output regardless of in_dest, because body flits carry no destination.
- Candidates for an unlocked output o:
  - Every unlocked input i with in_req[i]=1, in_dest[i]=o and i≠o.
  - Pick the first candidate scanning i = rr_ptr[o], rr_ptr[o]+1, … mod 5.
- Locked output o: the candidate is lock_src[o] if in_req[lock_src]=1, otherwise none (bubble; lock holds).
- Output o fires when a candidate exists and out_ready[o]=1, all in the same cycle (combinational, zero latency):
  - out_valid[o]=1.
  - o_port_select=candidate.
  - in_grant[candidate]=1.
- No candidate or out_ready[o]=0:
  - out_valid[o]=0, select=3'b111, no grant.
  - State unchanged; the pointer does not advance.
- Next-state update on a fire:
  - Non-tail flit with ENABLE_LOCK=1: lock_v[o]←1, lock_src[o]←src, rr_ptr unchanged.
  - Tail flit, or ENABLE_LOCK=0: lock_v[o]←0, rr_ptr[o]←(src+1) mod 5.
  - A single-flit packet (head is tail) never locks.
- Illegal head request: an unlocked input with in_req=1 and either in_dest>4 or in_dest==i.
  - It is never granted.
  - alloc_err=1 in each such cycle.
  - Other ports are unaffected.
- Each input is granted at most once per cycle; each select value appears on at most one output.
- Simultaneous tail-grant on o and a new head for o in the same cycle: the new head waits. It is arbitrated next cycle with the updated rr_ptr.
- Reset mid-packet: all locks are dropped immediately. Remaining body flits then arrive as unlocked heads; upstream must flush its buffers on reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_req=5'b11111 → in_grant=0, out_valid=0, all selects=3'b111. After release, all rr_ptr=0 (probed via first arbitration).
- Single flit: in_req[S]=1, in_dest[S]=4, in_tail[S]=1, out_ready=5'b11111 → same cycle L_port_select=1, out_valid[L]=1, in_grant=5'b00010. Next cycle rr_ptr[L]=2.
- Round-robin: N, E and W all request L with single flits, held for 3 cycles → grant order N(0), E(2), W(3); each grant one cycle.
- Wormhole lock: a 3-flit packet E→N (tail on the 3rd flit) while W also requests N → N_port_select=2 for 3 grant cycles. A mid-packet in_req[E]=0 bubble gives out_valid[N]=0 and W is not granted. W is granted the cycle after E's tail.
- Backpressure: a locked packet with out_ready[S]=0 for 2 cycles → no grant, lock and rr_ptr held. Resumes when out_ready[S]=1.
- Illegal: in_req[W]=1, in_dest[W]=3, plus an unlocked head with dest 6 → never granted, alloc_err=1 each cycle. A concurrent legal N→L flit is granted normally.
